// File: rtl/sa_stream_ctrl.sv
// Job sequencer for one sa_bitstream_gen: loads k, streams len bits through a
// 1-entry registered valid/ready buffer, and reports accepted ones/length on completion.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for a job request, req_ready high
//   LOAD   | generator start pulse, accumulator reloads to L/2
//   RUN    | pulling bits from the generator into the output buffer
//   DONE   | one-cycle completion pulse, result fields valid
module sa_stream_ctrl #(
    parameter int N = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [N-1:0] req_k,
    input  logic [N:0]   req_len,
    input  logic         abort,
    output logic         gen_start,
    output logic         gen_enable,
    output logic [N-1:0] gen_k,
    input  logic         gen_x,
    output logic         bit_valid,
    output logic         bit_data,
    output logic         bit_last,
    input  logic         bit_ready,
    output logic         done,
    output logic [N:0]   done_ones,
    output logic [N:0]   done_len,
    output logic         done_aborted,
    output logic         busy
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    localparam logic [N:0] LEN_FULL = {1'b1, {N{1'b0}}};
    localparam logic [N:0] ONE      = {{N{1'b0}}, 1'b1};

    state_t       state_q, state_d;
    logic [N-1:0] k_q;
    logic [N:0]   len_q, issued_q, acc_q, ones_q;
    logic         aborted_q, bit_valid_q, bit_data_q, bit_last_q;
    logic [N:0]   len_eff;
    logic         accept, pull, hs, last_hs, abort_eff;

    // A zero or oversized length means a full 2^N-bit stream.
    always_comb begin
        len_eff = req_len;
        if (req_len == '0 || req_len > LEN_FULL)
            len_eff = LEN_FULL;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (req_valid) state_d = S_LOAD;
            S_LOAD: state_d = abort ? S_DONE : S_RUN;
            S_RUN:  if (last_hs || abort) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == S_IDLE);
        gen_start  = (state_q == S_LOAD);
        busy       = (state_q != S_IDLE);
        done       = (state_q == S_DONE);
        accept     = req_ready & req_valid;
        hs         = (state_q == S_RUN) & bit_valid_q & bit_ready;
        last_hs    = hs & bit_last_q;
        // The generator only advances when the buffer is empty or draining this cycle.
        pull       = (state_q == S_RUN) & (issued_q < len_q) & (!bit_valid_q | bit_ready);
        gen_enable = pull;
        abort_eff  = abort & ((state_q == S_LOAD) | (state_q == S_RUN)) & !last_hs;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k_q         <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            acc_q       <= '0;
            ones_q      <= '0;
            aborted_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            bit_data_q  <= 1'b0;
            bit_last_q  <= 1'b0;
        end else begin
            if (accept) begin
                k_q       <= req_k;
                len_q     <= len_eff;
                issued_q  <= '0;
                acc_q     <= '0;
                ones_q    <= '0;
                aborted_q <= 1'b0;
            end
            if (pull) begin
                bit_valid_q <= 1'b1;
                bit_data_q  <= gen_x;
                bit_last_q  <= (issued_q + ONE == len_q);
                issued_q    <= issued_q + ONE;
            end else if (hs) begin
                bit_valid_q <= 1'b0;
            end
            if (hs) begin
                acc_q  <= acc_q + ONE;
                ones_q <= ones_q + {{N{1'b0}}, bit_data_q};
            end
            // Abort drops any buffered bit; a last-bit handshake in the same cycle wins.
            if (abort_eff) begin
                aborted_q   <= 1'b1;
                bit_valid_q <= 1'b0;
            end
        end
    end

    assign gen_k        = k_q;
    assign bit_valid    = bit_valid_q;
    assign bit_data     = bit_data_q;
    assign bit_last     = bit_last_q;
    assign done_ones    = ones_q;
    assign done_len     = acc_q;
    assign done_aborted = aborted_q;

endmodule

// File: doc/sa_stream_ctrl.md
Name: sa_stream_ctrl

Overview:
Request-driven sequencer for one sa_bitstream_gen instance. It accepts a job (value k, stream length), initialises the generator, and streams exactly that many bits to a consumer over a valid/ready port, using a 1-entry registered output buffer. It counts the ones the consumer accepts and reports completion, which supports early termination (len < 2^N) and mid-stream abort.

Parameters:
N, 7, generator bit width; full stream length L = 2^N.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  job request valid
req_ready  out  1  controller can accept a job (high only in IDLE)
req_k  in  N  value to encode (probability k/2^N)
req_len  in  N+1  bits to emit; 0 means 2^N; values > 2^N are clamped to 2^N
abort  in  1  terminate current job
gen_start  out  1  to generator start
gen_enable  out  1  to generator enable
gen_k  out  N  to generator k (latched job value)
gen_x  in  1  generator x_out (combinational enable & overflow)
bit_valid  out  1  output bit valid (registered)
bit_data  out  1  output bit
bit_last  out  1  final bit of job, qualified by bit_valid
bit_ready  in  1  consumer ready
done  out  1  one-cycle completion pulse
done_ones  out  N+1  ones accepted by consumer, stable from done until next job accept
done_len  out  N+1  bits accepted by consumer, same stability
done_aborted  out  1  job ended by abort, same stability
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n low at posedge): state=IDLE; bit_valid, bit_data, bit_last, done, done_ones, done_len, done_aborted, gen_start, gen_enable = 0; gen_k=0; all counters 0. Reset mid-job drops the job silently, with no done pulse.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid: latch k into gen_k and the effective length len_q (N+1 bits), clear the counters, then go to LOAD.
- LOAD (1 cycle):
  - gen_start=1, gen_enable=0.
  - Go to RUN. The generator accumulator holds L/2 on entry to RUN.
- RUN:
  - issued counts bits pulled from the generator; acc counts bits accepted by the consumer.
  - Pull condition: gen_enable = (issued < len_q) & (!bit_valid | bit_ready).
  - On pull: bit_data <= gen_x; bit_valid <= 1; bit_last <= (issued+1 == len_q); issued++.
  - On handshake (bit_valid & bit_ready) with no pull in the same cycle: bit_valid <= 0.
  - Each handshake: acc++; ones += bit_data.
  - A handshake with bit_last → DONE.
  - bit_data, bit_last stay stable while bit_valid & !bit_ready. The generator never advances while stalled.
- Throughput: with bit_ready held high, one bit per cycle.
- Latency: accept at cycle T → gen_start at T+1 → first gen_enable at T+2 → first bit_valid at T+3.
- DONE (1 cycle):
  - done=1; done_ones/done_len/done_aborted hold final values.
  - Next state IDLE; req_ready returns the cycle after done.
- abort (LOAD or RUN):
  - Next state is DONE with done_aborted=1.
  - A handshake in the abort cycle still counts.
  - The buffered bit (if not handshaken) is dropped: bit_valid <= 0.
  - If that same-cycle handshake is the last bit, the job completes normally with done_aborted=0.
  - abort in IDLE or DONE is ignored.
- No gen_enable outside RUN. No gen_start outside LOAD.
- Counter widths are N+1, so len = 2^N never wraps.

Test Plan:
- N=7, req_k=32, req_len=8, bit_ready=1 → bits 0,1,0,0,0,1,0,0; bit_last on the 8th bit; done_ones=2, done_len=8, done_aborted=0; first bit_valid 3 cycles after accept.
- req_k=64, req_len=4 → bits 1,0,1,0; done_ones=2. Then back-to-back req_k=127, req_len=0 → 128 bits, done_ones=127. Then req_k=0, req_len=0 → all zeros, done_ones=0.
- req_k=32, req_len=8 with bit_ready low for 5 cycles after the 2nd bit → same bit sequence as the first test; bit_data stable during the stall; no gen_enable while stalled.
- Abort after 3 accepted bits, no handshake in the abort cycle → done next cycle, done_len=3, done_aborted=1, buffered bit dropped. Abort coincident with the last handshake → done_aborted=0, done_len=len.
- Assert rst_n low mid-RUN → the next cycle has state IDLE, bit_valid=0, and no done. A new job then runs correctly starting from accumulator L/2.
- req_valid held high during RUN and DONE → req_ready=0 and no accept until IDLE; then exactly one accept.
